// File: rtl/gpu_arb_pkg.sv
// gpu_arb_pkg: shared widths and the queued command record for the GPU RAM arbiter
package gpu_arb_pkg;
   localparam int ADDR_W = 20;
   localparam int DATA_W = 16;
   typedef struct packed {
      logic              rd;
      logic              wr;
      logic              b16;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } cmd_t;
endpackage

// File: rtl/arb_cmd_fifo.sv
// arb_cmd_fifo: 2-entry first-word-fall-through command queue
//   clk, reset (async active-low); push/din write an entry, pop drops the head
//   dout is the current head, empty/full report occupancy 0/2
module arb_cmd_fifo import gpu_arb_pkg::*; #(
   parameter type T = cmd_t
) (
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  logic pop,
   input  T     din,
   output T     dout,
   output logic empty,
   output logic full
);
   T mem [2];
   logic wp, rp;
   logic [1:0] cnt;
   assign dout = mem[rp];
   assign empty = cnt == 2'd0;
   assign full = cnt == 2'd2;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wp <= 1'b0;
         rp <= 1'b0;
         cnt <= 2'd0;
      end else begin
         if (push) begin
            mem[wp] <= din;
            wp <= ~wp;
         end
         if (pop) rp <= ~rp;
         cnt <= cnt + {1'b0, push} - {1'b0, pop};
      end
endmodule

// File: rtl/gpu_ram_arbiter.sv
// gpu_ram_arbiter: round-robin GPU RAM arbiter with starvation override and read-return tagging
//   clk, reset (async active-low)
//   req_wr/req_rd/req_16bit/req_addr/req_data: per-port request (addr/data packed port-major)
//   port_full: per-port queue full; rd_rdy: per-port read-data-valid pulse; rd_data = gpu_data_in
//   gpu_wr_ena/gpu_rd_req/gpu_ena_16bit/gpu_address/gpu_data_out: registered RAM command
//   grant_id: port owning the current command
module gpu_ram_arbiter import gpu_arb_pkg::*; #(
   parameter int PORTS = 3,
   parameter int READ_CLOCK_CYCLES = 2,
   parameter int STARVE_LIMIT = 6
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [PORTS-1:0]        req_wr,
   input  logic [PORTS-1:0]        req_rd,
   input  logic [PORTS-1:0]        req_16bit,
   input  logic [PORTS*ADDR_W-1:0] req_addr,
   input  logic [PORTS*DATA_W-1:0] req_data,
   output logic [PORTS-1:0]        port_full,
   output logic [PORTS-1:0]        rd_rdy,
   output logic [DATA_W-1:0]       rd_data,
   output logic                    gpu_wr_ena,
   output logic                    gpu_rd_req,
   output logic                    gpu_ena_16bit,
   output logic [ADDR_W-1:0]       gpu_address,
   output logic [DATA_W-1:0]       gpu_data_out,
   input  logic [DATA_W-1:0]       gpu_data_in,
   output logic [1:0]              grant_id
);
   localparam int PW = PORTS > 1 ? $clog2(PORTS) : 1;
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   cmd_t head [PORTS];
   logic [PORTS-1:0] empty, pop;
   logic [PW-1:0] ptr, gsel, gid, idx;
   logic gv;
   logic [CW-1:0] wcnt [PORTS];
   logic tv [READ_CLOCK_CYCLES];
   logic [PW-1:0] tp [READ_CLOCK_CYCLES];
   genvar i;
   for (i = 0; i < PORTS; i = i + 1) begin : g_q
      cmd_t din;
      // a simultaneous write+read strobe is stored as a write only
      assign din = '{rd: req_rd[i] & ~req_wr[i], wr: req_wr[i], b16: req_16bit[i],
                     addr: req_addr[i*ADDR_W +: ADDR_W], data: req_data[i*DATA_W +: DATA_W]};
      arb_cmd_fifo #(.T(cmd_t)) u_q (
         .clk(clk), .reset(reset), .push((req_wr[i] | req_rd[i]) & ~port_full[i]), .pop(pop[i]),
         .din(din), .dout(head[i]), .empty(empty[i]), .full(port_full[i]));
   end
   // starved ports (lowest index first) beat the round-robin scan that starts after ptr
   always_comb begin
      gv = 1'b0;
      gsel = '0;
      idx = '0;
      for (int k = 0; k < PORTS; k++)
         if (!gv && !empty[k] && wcnt[k] == CW'(STARVE_LIMIT)) begin
            gv = 1'b1;
            gsel = PW'(k);
         end
      for (int k = 1; k <= PORTS; k++) begin
         idx = PW'((int'(ptr) + k) % PORTS);
         if (!gv && !empty[idx]) begin
            gv = 1'b1;
            gsel = idx;
         end
      end
   end
   assign pop = gv ? PORTS'(1) << gsel : '0;
   assign rd_data = gpu_data_in;
   assign grant_id = 2'(gid);
   always_comb begin
      rd_rdy = '0;
      if (tv[READ_CLOCK_CYCLES-1]) rd_rdy[tp[READ_CLOCK_CYCLES-1]] = 1'b1;
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         ptr <= PW'(PORTS - 1);
         gid <= '0;
         gpu_wr_ena <= 1'b0;
         gpu_rd_req <= 1'b0;
         gpu_ena_16bit <= 1'b0;
         gpu_address <= '0;
         gpu_data_out <= '0;
         for (int k = 0; k < PORTS; k++) wcnt[k] <= '0;
         for (int k = 0; k < READ_CLOCK_CYCLES; k++) begin
            tv[k] <= 1'b0;
            tp[k] <= '0;
         end
      end else begin
         gpu_wr_ena <= gv & head[gsel].wr;
         gpu_rd_req <= gv & head[gsel].rd;
         gpu_ena_16bit <= gv & head[gsel].b16;
         if (gv) begin
            ptr <= gsel;
            gid <= gsel;
            gpu_address <= head[gsel].addr;
            gpu_data_out <= head[gsel].data;
         end
         for (int k = 0; k < PORTS; k++)
            wcnt[k] <= (empty[k] || (gv && gsel == PW'(k))) ? '0 :
                       wcnt[k] == CW'(STARVE_LIMIT) ? wcnt[k] : wcnt[k] + 1'b1;
         // read-return tag: stage 0 captures the command cycle, the last stage drives rd_rdy
         tv[0] <= gpu_rd_req;
         tp[0] <= gid;
         for (int k = 1; k < READ_CLOCK_CYCLES; k++) begin
            tv[k] <= tv[k-1];
            tp[k] <= tp[k-1];
         end
      end
endmodule

// File: tb/tb_gpu_ram_arbiter.sv
// tb_gpu_ram_arbiter: table, directed and randomized checks of gpu_ram_arbiter against a queue model
module tb_gpu_ram_arbiter;
   import gpu_arb_pkg::*;
   localparam int R = 2;
   localparam int SL = 2;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic [2:0] req_wr = '0, req_rd = '0, req_16bit = '0;
   logic [59:0] req_addr = '0;
   logic [47:0] req_data = '0;
   logic [2:0] port_full, rd_rdy;
   logic [15:0] rd_data, gpu_data_out;
   logic [15:0] gpu_data_in = '0;
   logic gpu_wr_ena, gpu_rd_req, gpu_ena_16bit;
   logic [19:0] gpu_address;
   logic [1:0] grant_id;
   int checks = 0, failures = 0;
   always #5 clk = ~clk;
   gpu_ram_arbiter #(.PORTS(3), .READ_CLOCK_CYCLES(R), .STARVE_LIMIT(SL)) dut (
      .clk(clk), .reset(reset), .req_wr(req_wr), .req_rd(req_rd), .req_16bit(req_16bit),
      .req_addr(req_addr), .req_data(req_data), .port_full(port_full), .rd_rdy(rd_rdy),
      .rd_data(rd_data), .gpu_wr_ena(gpu_wr_ena), .gpu_rd_req(gpu_rd_req),
      .gpu_ena_16bit(gpu_ena_16bit), .gpu_address(gpu_address), .gpu_data_out(gpu_data_out),
      .gpu_data_in(gpu_data_in), .grant_id(grant_id));
   cmd_t mq [3][$];
   int wc [3];
   int ptr, cyc;
   logic [2:0] rdy_at [int];
   logic e_wr, e_rd, e_b16;
   logic [19:0] e_addr;
   logic [15:0] e_data;
   logic [1:0] e_gid;
   function automatic void model_reset();
      for (int i = 0; i < 3; i++) begin
         mq[i].delete();
         wc[i] = 0;
      end
      ptr = 2;
      rdy_at.delete();
      {e_wr, e_rd, e_b16, e_addr, e_data, e_gid} = '0;
   endfunction
   function automatic void model_step();
      int g = -1;
      bit [2:0] nf, ne;
      cmd_t c;
      cyc++;
      for (int i = 0; i < 3; i++) begin
         nf[i] = mq[i].size() == 2;
         ne[i] = mq[i].size() != 0;
      end
      for (int i = 0; i < 3; i++) if (g < 0 && ne[i] && wc[i] == SL) g = i;
      for (int k = 1; k <= 3; k++) if (g < 0 && ne[(ptr + k) % 3]) g = (ptr + k) % 3;
      {e_wr, e_rd, e_b16} = '0;
      if (g >= 0) begin
         c = mq[g].pop_front();
         {e_wr, e_rd, e_b16, e_addr, e_data, e_gid} = {c.wr, c.rd, c.b16, c.addr, c.data, 2'(g)};
         ptr = g;
         if (c.rd) rdy_at[cyc + R] = 3'b1 << g;
      end
      for (int i = 0; i < 3; i++) begin
         if ((req_wr[i] | req_rd[i]) && !nf[i])
            mq[i].push_back('{rd: req_rd[i] & ~req_wr[i], wr: req_wr[i], b16: req_16bit[i],
                              addr: req_addr[i*20 +: 20], data: req_data[i*16 +: 16]});
         wc[i] = (!ne[i] || i == g) ? 0 : (wc[i] < SL ? wc[i] + 1 : wc[i]);
      end
   endfunction
   function automatic logic [62:0] exp_out();
      logic [2:0] f;
      for (int i = 0; i < 3; i++) f[i] = mq[i].size() == 2;
      return {f, rdy_at.exists(cyc) ? rdy_at[cyc] : 3'b0, e_wr, e_rd, e_b16, e_addr, e_data, e_gid, gpu_data_in};
   endfunction
   function automatic logic [62:0] dut_out();
      return {port_full, rd_rdy, gpu_wr_ena, gpu_rd_req, gpu_ena_16bit, gpu_address, gpu_data_out, grant_id, rd_data};
   endfunction
   task automatic check(input string name, input logic [62:0] got, input logic [62:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
      end
   endtask
   task automatic tick(input string name);
      @(posedge clk);
      if (reset) model_step();
      else model_reset();
      @(negedge clk);
      check(name, dut_out(), exp_out());
   endtask
   task automatic set_req(input int p, input bit w, input bit r, input bit b, input logic [19:0] a, input logic [15:0] d);
      req_wr[p] = w;
      req_rd[p] = r;
      req_16bit[p] = b;
      req_addr[p*20 +: 20] = a;
      req_data[p*16 +: 16] = d;
   endtask
   task automatic clr();
      for (int p = 0; p < 3; p++) set_req(p, 0, 0, 0, '0, '0);
   endtask
   task automatic do_reset();
      reset = 1'b0;
      #1;
      model_reset();
      check("reset_outs", dut_out(), 63'(gpu_data_in));
      repeat (2) tick("in_reset");
      reset = 1'b1;
   endtask
   typedef struct {
      bit rd, wr, b16;
      logic [19:0] a;
      logic [15:0] d;
      bit x_wr, x_rd, x_b16, x_rdy;
   } vec_t;
   vec_t tbl [4];
   int ng, p2_seen, bad, lat, seen;
   initial begin
      tbl[0] = '{1, 0, 0, 20'h00010, 16'h0000, 0, 1, 0, 1};
      tbl[1] = '{1, 1, 1, 20'h12345, 16'hBEEF, 1, 0, 1, 0};
      tbl[2] = '{0, 1, 0, 20'hFFFFF, 16'h00A5, 1, 0, 0, 0};
      tbl[3] = '{1, 0, 1, 20'h00000, 16'h1234, 0, 1, 1, 1};
      cyc = 0;
      model_reset();
      repeat (2) tick("in_reset");
      check("reset_state", dut_out(), 63'(gpu_data_in));
      reset = 1'b1;
      foreach (tbl[v]) begin
         set_req(0, tbl[v].wr, tbl[v].rd, tbl[v].b16, tbl[v].a, tbl[v].d);
         tick("vec_push");
         check("vec_idle", 63'({gpu_wr_ena, gpu_rd_req, gpu_ena_16bit}), 63'(0));
         clr();
         tick("vec_issue");
         check("vec_cmd", 63'({gpu_wr_ena, gpu_rd_req, gpu_ena_16bit, gpu_address, gpu_data_out, grant_id}),
               63'({tbl[v].x_wr, tbl[v].x_rd, tbl[v].x_b16, tbl[v].a, tbl[v].d, 2'd0}));
         repeat (R - 1) begin
            tick("vec_wait");
            check("vec_rdy_early", 63'(rd_rdy), 63'(0));
         end
         gpu_data_in = 16'($urandom);
         tick("vec_rdy");
         check("vec_rdy", 63'({rd_rdy, rd_data}), 63'({2'b0, tbl[v].x_rdy, gpu_data_in}));
         tick("vec_after");
         check("vec_rdy_pulse", 63'(rd_rdy), 63'(0));
      end
      set_req(0, 0, 1, 0, 20'h00444, 16'h0000);
      tick("r37_push");
      clr();
      tick("r37_issue");
      check("r37_rd_req", 63'(gpu_rd_req), 63'(1));
      tick("r37_after");
      do_reset();
      seen = 0;
      repeat (R + 3) begin
         tick("r37_post");
         seen |= int'(rd_rdy);
      end
      check("r37_no_rdy", 63'(seen), 63'(0));
      ng = 0;
      for (int n = 0; n < 14; n++) begin
         for (int p = 0; p < 3; p++) set_req(p, 1, 0, 0, 20'($urandom), 16'($urandom));
         tick("r34");
         if (gpu_wr_ena) begin
            check("r34_rotate", 63'(grant_id), 63'(ng % 3));
            ng++;
         end
      end
      check("r34_grants", 63'(ng), 63'(13));
      clr();
      repeat (8) tick("r34_drain");
      do_reset();
      p2_seen = 0;
      bad = 0;
      for (int n = 0; n < 20; n++) begin
         clr();
         if (n < 6) for (int p = 0; p < 2; p++) set_req(p, 1, 0, 0, 20'h11000 + 20'(n), 16'h1111);
         if (n < 4) set_req(2, 1, 0, 0, 20'hA0000 + 20'(n), 16'h2222);
         tick("r35");
         if (n == 1) check("r35_full_after_2nd", 63'(port_full[2]), 63'(1));
         if (gpu_wr_ena && grant_id == 2'd2) begin
            p2_seen++;
            if (gpu_address == 20'hA0002 || gpu_address == 20'hA0003) bad++;
         end
      end
      check("r35_p2_count", 63'(p2_seen), 63'(2));
      check("r35_dropped", 63'(bad), 63'(0));
      do_reset();
      lat = 99;
      for (int n = 0; n < 14; n++) begin
         clr();
         if (n < 10) begin
            set_req(0, 1, 0, 0, 20'h20000 + 20'(n), 16'h0);
            set_req(2, 1, 0, 0, 20'h22000 + 20'(n), 16'h2);
         end
         if (n == 2) set_req(1, 1, 0, 0, 20'h21111, 16'h1);
         tick("r36");
         if (n > 2 && lat == 99 && gpu_wr_ena && grant_id == 2'd1) lat = n - 2;
      end
      check("r36_starve_bound", 63'(lat <= 4), 63'(1));
      clr();
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         for (int p = 0; p < 3; p++)
            if ($urandom_range(99) < 45)
               set_req(p, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)), 20'($urandom), 16'($urandom));
            else set_req(p, 0, 0, 0, '0, '0);
         gpu_data_in = 16'($urandom);
         if (n == 1500) do_reset();
         tick("rand");
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/gpu_ram_arbiter.md
GPU_RAM_ARBITER -- requirements
Module: gpu_ram_arbiter

Interface
REQ-001 SHALL have parameter PORTS, default 3, number of requesters (port 0 = Z80, 1 = RS232, 2 = geometry).
REQ-002 SHALL have parameter READ_CLOCK_CYCLES, default 2, GPU RAM read latency in clocks (1..8).
REQ-003 SHALL have parameter STARVE_LIMIT, default 6, wait cycles after which a queued port is force-granted.
REQ-004 SHALL have ports: clk  in  1  sole clock; one clock, rising edge.
REQ-005 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: req_wr  in  PORTS  write request strobe per port.
REQ-007 SHALL have ports: req_rd  in  PORTS  read request strobe per port.
REQ-008 SHALL have ports: req_16bit  in  PORTS  16-bit access flag per port.
REQ-009 SHALL have ports: req_addr  in  PORTS x 20  byte address per port.
REQ-010 SHALL have ports: req_data  in  PORTS x 16  write data per port (8-bit accesses use [7:0]).
REQ-011 SHALL have ports: port_full  out  PORTS  queue full per port.
REQ-012 SHALL have ports: rd_rdy  out  PORTS  one-clock pulse, read data valid for that port.
REQ-013 SHALL have ports: rd_data  out  16  read data, equal to gpu_data_in.
REQ-014 SHALL have ports: gpu_wr_ena, gpu_rd_req, gpu_ena_16bit  out  1 each  RAM command strobes.
REQ-015 SHALL have ports: gpu_address  out  20; gpu_data_out  out  16; gpu_data_in  in  16; grant_id  out  2 (port of current command).

Function
REQ-016 Each port SHALL own a 2-entry first-word-fall-through queue storing {rd, wr, 16bit, addr, data}.
REQ-017 A push SHALL occur on an edge where (req_wr|req_rd) is high and port_full is low; a request while port_full is high SHALL be dropped, even if a pop occurs in the same cycle.
REQ-018 port_full SHALL be high exactly when that queue holds 2 entries; a simultaneous push and pop at 1 entry SHALL leave 1 entry.
REQ-019 When req_wr and req_rd are both high, the entry SHALL be a write only; no rd_rdy SHALL follow.
REQ-020 Each cycle the arbiter SHALL grant at most one non-empty queue and pop it.
REQ-021 Selection SHALL be round-robin, starting from the port after the last granted port.
REQ-022 Each port SHALL have a wait counter, incremented while its queue is non-empty and not granted, cleared on grant or when empty; saturating at STARVE_LIMIT.
REQ-023 Any port whose counter equals STARVE_LIMIT SHALL override round-robin; the lowest-index starved port wins.
REQ-024 gpu_* outputs and grant_id SHALL be registered; the granted command appears on the edge after the grant and strobes SHALL be high for exactly one clock.
REQ-025 Uncontended latency SHALL be request edge T -> gpu strobe high after edge T+1 (2 clocks).
REQ-026 With no grant, gpu_wr_ena, gpu_rd_req and gpu_ena_16bit SHALL be 0, and address and data SHALL hold their last values.
REQ-027 A {valid, port} tag pipeline of depth READ_CLOCK_CYCLES SHALL pulse rd_rdy[port] exactly READ_CLOCK_CYCLES clocks after the gpu_rd_req cycle; back-to-back reads SHALL produce back-to-back pulses.
REQ-028 rd_data SHALL be combinational from gpu_data_in; the requester latches it on rd_rdy.

Reset
REQ-029 While reset is low, all queues SHALL be empty, port_full and rd_rdy SHALL be 0, gpu strobes SHALL be 0, and gpu_address, gpu_data_out and grant_id SHALL be 0.
REQ-030 While reset is low, wait counters and tag pipeline SHALL clear and the round-robin pointer SHALL be PORTS-1, so port 0 wins first; in-flight reads asserted before reset SHALL never produce rd_rdy.

Structure
REQ-031 Package gpu_arb_pkg SHALL hold ADDR_W=20, DATA_W=16, and typedef cmd_t {rd, wr, b16, addr, data}.
REQ-032 The queue SHALL be sub-module arb_cmd_fifo (parameterised on cmd_t), instantiated PORTS times.

Verification
REQ-033 The bench SHALL cover: a single port-0 read of 0x00010 with READ_CLOCK_CYCLES=2 -> gpu_rd_req is high 2 clocks later and rd_rdy[0] pulses 2 clocks after that, with rd_data = gpu_data_in.
REQ-034 The bench SHALL cover: all 3 ports pushing a write every cycle -> grants rotate 0,1,2,0,..., with no port granted twice before the others.
REQ-035 The bench SHALL cover: 3 pushes to port 2 in consecutive cycles with ports 0 and 1 saturating the queue -> port_full[2] is high after the 2nd push and the 3rd request is dropped (never reaching gpu).
REQ-036 The bench SHALL cover: port 1 queued while ports 0 and 2 are favoured by the pointer, with STARVE_LIMIT=2 -> port 1 is granted no later than the 3rd waiting cycle.
REQ-037 The bench SHALL cover: reset asserted 1 clock after gpu_rd_req -> no rd_rdy ever, all outputs 0, and the first post-reset grant goes to port 0.
REQ-038 The bench SHALL cover: req_wr=req_rd=1 on port 0 with 16bit=1 and data 0xBEEF -> gpu_wr_ena=1, gpu_ena_16bit=1, gpu_data_out=0xBEEF, and no rd_rdy.
